// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default pointer width and Gray/binary conversions.
// The conversions work on 32-bit words; callers zero-extend narrower pointers
// and truncate the result. Zero upper bits leave the low bits unchanged in
// both directions.
package fifo_pkg;

    localparam int DEFAULT_PTR_WIDTH = 3;
    localparam int CONV_WIDTH        = 32;

    // Binary to reflected Gray code.
    function automatic logic [CONV_WIDTH-1:0] bin2gray(input logic [CONV_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary (XOR prefix from the MSB down).
    function automatic logic [CONV_WIDTH-1:0] gray2bin(input logic [CONV_WIDTH-1:0] g);
        logic [CONV_WIDTH-1:0] b;
        b = g;
        for (int i = CONV_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parametrised width.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // XOR prefix from the MSB down; a local copy avoids a self-referencing net chain.
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc = i_gray;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ i_gray[i];
        end
        o_bin = acc;
    end

endmodule

// File: rtl/rdptr_flags.sv
// Read-side pointer and status flags of an asynchronous FIFO.
// Keeps the binary read pointer, publishes its Gray form for the write
// domain, and derives empty / almost-empty / fill level from the
// synchronised write pointer. All flags are registered and are computed from
// the next pointer value, so they reflect a read on the same edge that
// accepts it.
//
// Read handshake: i_rd_en is the consumer's request and !o_empty is the
// producer-side ready. A read is accepted on a rising edge where both are
// high, and the data at o_rdaddr is consumed on that edge. A request while
// o_empty is high is not accepted. It leaves the pointer untouched and
// raises the sticky o_underflow flag.
module rdptr_flags
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH
) (
    input  logic                 i_rd_clk,
    input  logic                 i_rst,
    input  logic                 i_rd_en,
    input  logic [PTR_WIDTH:0]   i_wrptr_gray_sync,
    input  logic [PTR_WIDTH:0]   i_aempty_thresh,
    input  logic                 i_clr_err,
    output logic [PTR_WIDTH:0]   o_rdptr_gray,
    output logic [PTR_WIDTH-1:0] o_rdaddr,
    output logic                 o_empty,
    output logic                 o_aempty,
    output logic [PTR_WIDTH:0]   o_rd_count,
    output logic                 o_underflow
);

    localparam int PW1 = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] rbin_next;
    logic [PTR_WIDTH:0] rgray_next;
    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] count_next;
    logic               rd_inc;
    logic               underflow_set;
    logic               underflow_next;

    // Write pointer converted back to binary so the fill level is plain subtraction.
    gray2bin #(
        .WIDTH (PW1)
    ) u_wr_g2b (
        .i_gray (i_wrptr_gray_sync),
        .o_bin  (wbin)
    );

    // Next-state values: accepted read, advanced pointer, its Gray form, fill level, sticky error.
    always_comb begin
        rd_inc         = i_rd_en & ~o_empty;
        rbin_next      = rbin + PW1'(rd_inc);
        rgray_next     = PW1'(bin2gray(CONV_WIDTH'(rbin_next)));
        count_next     = wbin - rbin_next;
        underflow_set  = i_rd_en & o_empty;
        // Set has priority over clear so an error raised during a clear is not lost.
        underflow_next = underflow_set | (o_underflow & ~i_clr_err);
    end

    // Pointer and flag registers; reset overrides any pending read or clear.
    always_ff @(posedge i_rd_clk) begin
        if (i_rst) begin
            rbin         <= '0;
            o_rdptr_gray <= '0;
            o_empty      <= 1'b1;
            o_aempty     <= 1'b1;
            o_rd_count   <= '0;
            o_underflow  <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            o_rdptr_gray <= rgray_next;
            o_empty      <= (rgray_next == i_wrptr_gray_sync);
            o_aempty     <= (count_next <= i_aempty_thresh);
            o_rd_count   <= count_next;
            o_underflow  <= underflow_next;
        end
    end

    // RAM address is the low part of the registered binary pointer; the MSB is the wrap bit.
    assign o_rdaddr = rbin[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_rdptr_flags.sv
// Bench for rdptr_flags at PTR_WIDTH=3: directed table, hand-written wrap
// sequence, and randomized traffic against a fill-level reference model.
module tb_rdptr_flags;

  localparam int PW = 3;
  localparam int W  = 14;  // {gray4, addr3, empty, aempty, count4, uf}

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic [PW:0]   wrptr_gray_sync;
  logic [PW:0]   aempty_thresh;
  logic          clr_err;
  logic [PW:0]   rdptr_gray;
  logic [PW-1:0] rdaddr;
  logic          empty;
  logic          aempty;
  logic [PW:0]   rd_count;
  logic          underflow;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  rdptr_flags #(.PTR_WIDTH(PW)) dut (
    .i_rd_clk          (clk),
    .i_rst             (rst),
    .i_rd_en           (rd_en),
    .i_wrptr_gray_sync (wrptr_gray_sync),
    .i_aempty_thresh   (aempty_thresh),
    .i_clr_err         (clr_err),
    .o_rdptr_gray      (rdptr_gray),
    .o_rdaddr          (rdaddr),
    .o_empty           (empty),
    .o_aempty          (aempty),
    .o_rd_count        (rd_count),
    .o_underflow       (underflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_gray(input int n);
    int m;
    m = n % 16;
    return m ^ (m >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // driver: apply inputs, then advance one edge and settle
  task automatic drive(input logic r, input logic rd, input logic clr, input int wr, input int thr);
    rst             = r;
    rd_en           = rd;
    clr_err         = clr;
    wrptr_gray_sync = 4'(to_gray(wr));
    aempty_thresh   = 4'(thr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic rd;
    logic clr;
    int   wr;
    int   thr;
    int   e_cnt;
    int   e_empty;
    int   e_aempty;
    int   e_uf;
    int   e_addr;
    int   e_gray;
  } vec_t;

  vec_t tbl[17];

  // reference model state (higher level: unbounded read/write totals)
  int  m_rd;
  int  m_wr;
  bit  m_empty;
  bit  m_uf;

  function automatic logic [W-1:0] model_step(input bit r, input bit rd, input bit clr, input int thr);
    int fill;
    bit acc;
    logic [W-1:0] e;
    if (r) begin
      m_rd = 0; m_empty = 1; m_uf = 0;
      e = {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0};
      return e;
    end
    acc  = rd && !m_empty;
    m_uf = (rd && m_empty) || (m_uf && !clr);
    m_rd = m_rd + int'(acc);
    fill = m_wr - m_rd;
    m_empty = (fill == 0);
    e = {4'(to_gray(m_rd)), 3'(m_rd % 8), m_empty, (fill <= thr), 4'(fill), m_uf};
    return e;
  endfunction

  initial begin
    logic [W-1:0] e;
    logic [PW:0]  prev_gray;
    total = 0;
    bad   = 0;
    rst = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    wrptr_gray_sync = '0; aempty_thresh = '0;

    //             rst rd clr wr thr cnt emp aem uf addr gray
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4, 1, 4, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4, 1, 3, 0, 0, 0, 1, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4, 1, 2, 0, 0, 0, 2, 3};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4, 1, 1, 0, 1, 0, 3, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4, 1, 0, 1, 1, 0, 4, 6};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4, 1, 0, 1, 1, 1, 4, 6};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4, 1, 0, 1, 1, 1, 4, 6};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4, 1, 0, 1, 1, 0, 4, 6};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4, 1, 0, 1, 1, 1, 4, 6};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4, 1, 0, 1, 1, 1, 4, 6};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4, 0, 0, 1, 1, 0, 4, 6};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 9, 1, 5, 0, 0, 1, 4, 6};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 9, 1, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 3, 0, 3, 0, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 3, 3, 2, 0, 1, 0, 1, 1};

    // directed table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].rd, tbl[i].clr, tbl[i].wr, tbl[i].thr);
      chk($sformatf("tbl%0d_count", i),  int'(rd_count),   tbl[i].e_cnt);
      chk($sformatf("tbl%0d_empty", i),  int'(empty),      tbl[i].e_empty);
      chk($sformatf("tbl%0d_aempty", i), int'(aempty),     tbl[i].e_aempty);
      chk($sformatf("tbl%0d_uf", i),     int'(underflow),  tbl[i].e_uf);
      chk($sformatf("tbl%0d_addr", i),   int'(rdaddr),     tbl[i].e_addr);
      chk($sformatf("tbl%0d_gray", i),   int'(rdptr_gray), tbl[i].e_gray);
    end

    // full wrap: 16 reads with the writer one entry ahead
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 2, 0);
    chk("wrap_pre_count", int'(rd_count), 2);
    prev_gray = rdptr_gray;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, (i + 1) % 16, 0);
      chk($sformatf("wrap%0d_onebit", i), $countones(prev_gray ^ rdptr_gray), 1);
      chk($sformatf("wrap%0d_gray", i),   int'(rdptr_gray), to_gray(i));
      chk($sformatf("wrap%0d_addr", i),   int'(rdaddr), i % 8);
      chk($sformatf("wrap%0d_count", i),  int'(rd_count), 1);
      prev_gray = rdptr_gray;
    end
    chk("wrap_final_gray", int'(rdptr_gray), 0);

    // randomized traffic against the model
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    m_wr = 0;
    e = model_step(1'b1, 1'b0, 1'b0, 0);
    for (int c = 0; c < 400; c++) begin
      bit r, rd, clr;
      int thr;
      r   = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      thr = $urandom_range(0, 8);
      if (r) m_wr = 0;
      else if ((m_wr - m_rd) < 8 && $urandom_range(0, 1) == 1) m_wr = m_wr + 1;
      exp_q.push_back(model_step(r, rd, clr, thr));
      drive(r, rd, clr, m_wr, thr);
      e = exp_q.pop_front();
      chk("rnd_gray",   int'(rdptr_gray), int'(e[13:10]));
      chk("rnd_addr",   int'(rdaddr),     int'(e[9:7]));
      chk("rnd_empty",  int'(empty),      int'(e[6]));
      chk("rnd_aempty", int'(aempty),     int'(e[5]));
      chk("rnd_count",  int'(rd_count),   int'(e[4:1]));
      chk("rnd_uf",     int'(underflow),  int'(e[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
